// File: rtl/adc_frame_reader.sv
// rtl/adc_frame_reader.sv - reads one frame of packed 16-bit pixels from RAM and streams them out
//
// Purpose: after the capture writer signals frame_done_in, fetch WORD_NUM 32-bit words
// starting at BASE_ADDR, buffer them in a 4-entry FIFO and unpack each word into two
// pixels (high half first) on a valid/ready pixel stream.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   frame_done_in       pulse that starts readout of a captured frame
//   ram_rd_o            RAM read strobe, one word per asserted cycle
//   ram_addr_o          RAM byte address (4-aligned)
//   ram_data_in         RAM read data, valid 2 cycles after ram_rd_o
//   pix_data_o          pixel data
//   pix_valid_o         pixel valid
//   pix_ready_in        pixel ready from the sink
//   pix_last_o          final pixel of the frame
//   busy_o              a frame is being read out
//   overrun_o           frame_done_in arrived while busy (one-cycle pulse)
//
// Build option: ADC_FRAME_READER_BYTESWAP_EN swaps the two bytes of every output pixel.
module adc_frame_reader #(
  parameter int unsigned WORD_NUM  = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_done_in,
  output logic        ram_rd_o,
  output logic [31:0] ram_addr_o,
  input  logic [31:0] ram_data_in,
  output logic [15:0] pix_data_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_in,
  output logic        pix_last_o,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [16:0] WORD_LAST = 17'(WORD_NUM - 1);
  localparam logic [16:0] PIX_LAST  = 17'(2 * WORD_NUM - 1);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [16:0] rd_cnt;
  logic [16:0] pix_cnt;
  logic        rd_d1;
  logic        rd_d2;
  logic [31:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  fifo_count;
  logic        half;

  logic [3:0]  occupancy;
  logic        rd_issue;
  logic        fifo_push;
  logic        fifo_pop;
  logic        xfer;
  logic        last_xfer;
  logic        start;
  logic        busy_int;
  logic [31:0] cur_word;
  logic [15:0] cur_pix;

  // Words buffered plus words still travelling through the 2-cycle RAM pipe; capping
  // this at 4 guarantees every returning word has a FIFO slot.
  assign occupancy = {1'b0, fifo_count} + {3'b000, rd_d1} + {3'b000, rd_d2};
  assign rd_issue  = rst_n && (state == S_FETCH) && (occupancy < 4'd4);
  assign fifo_push = rd_d2;

  assign busy_int    = (state != S_IDLE);
  assign pix_valid_o = rst_n && (fifo_count != 3'd0);
  assign pix_last_o  = pix_valid_o && (pix_cnt == PIX_LAST);
  assign xfer        = pix_valid_o && pix_ready_in;
  assign last_xfer   = xfer && (pix_cnt == PIX_LAST);
  assign fifo_pop    = xfer && half;

  // A frame_done_in coinciding with the final handshake chains straight into a new frame.
  assign start = frame_done_in && ((state == S_IDLE) || last_xfer);

  assign ram_rd_o   = rd_issue;
  assign ram_addr_o = rst_n ? addr_q : BASE_ADDR;
  assign busy_o     = rst_n && busy_int;
  assign overrun_o  = rst_n && frame_done_in && busy_int && !last_xfer;

  assign cur_word = fifo_mem[rd_ptr];
  assign cur_pix  = half ? cur_word[15:0] : cur_word[31:16];

`ifdef ADC_FRAME_READER_BYTESWAP_EN
  assign pix_data_o = {cur_pix[7:0], cur_pix[15:8]};
`else
  assign pix_data_o = cur_pix;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_q     <= BASE_ADDR;
      rd_cnt     <= '0;
      pix_cnt    <= '0;
      half       <= 1'b0;
      rd_d1      <= 1'b0;
      rd_d2      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_FETCH;
        S_FETCH: if (rd_issue && (rd_cnt == WORD_LAST)) state <= S_DRAIN;
        S_DRAIN: if (last_xfer) state <= start ? S_FETCH : S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (start) begin
        addr_q  <= BASE_ADDR;
        rd_cnt  <= '0;
        pix_cnt <= '0;
        half    <= 1'b0;
      end else begin
        if (rd_issue) begin
          addr_q <= addr_q + 32'd4;
          rd_cnt <= rd_cnt + 17'd1;
        end
        if (xfer) begin
          pix_cnt <= pix_cnt + 17'd1;
          half    <= ~half;
        end
      end

      // Clearing this pipe on reset is what discards data returning after an abort.
      rd_d1 <= rd_issue;
      rd_d2 <= rd_d1;

      if (fifo_push) wr_ptr <= wr_ptr + 2'd1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= ram_data_in;
  end

endmodule

// File: tb/tb_adc_frame_reader.sv
// tb/tb_adc_frame_reader.sv - scoreboard bench for adc_frame_reader
module tb_adc_frame_reader;

  localparam int          WN = 4;
  localparam logic [31:0] BA = 32'h40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_done;
  logic        rd;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [15:0] pd;
  logic        pv;
  logic        pr;
  logic        pl;
  logic        busy;
  logic        ovr;

  logic        frame_done1;
  logic        rd1;
  logic [31:0] addr1;
  logic [31:0] rdata1;
  logic [15:0] pd1;
  logic        pv1;
  logic        pr1;
  logic        pl1;
  logic        busy1;
  logic        ovr1;

  adc_frame_reader #(.WORD_NUM(WN), .BASE_ADDR(BA)) dut (
    .clk(clk), .rst_n(rst_n), .frame_done_in(frame_done),
    .ram_rd_o(rd), .ram_addr_o(addr), .ram_data_in(rdata),
    .pix_data_o(pd), .pix_valid_o(pv), .pix_ready_in(pr), .pix_last_o(pl),
    .busy_o(busy), .overrun_o(ovr)
  );

  adc_frame_reader #(.WORD_NUM(1), .BASE_ADDR(32'h100)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_done_in(frame_done1),
    .ram_rd_o(rd1), .ram_addr_o(addr1), .ram_data_in(rdata1),
    .pix_data_o(pd1), .pix_valid_o(pv1), .pix_ready_in(pr1), .pix_last_o(pl1),
    .busy_o(busy1), .overrun_o(ovr1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pix_fmt(input logic [15:0] p);
`ifdef ADC_FRAME_READER_BYTESWAP_EN
    return {p[7:0], p[15:8]};
`else
    return p;
`endif
  endfunction

  // RAM models: data for a read appears two cycles after the strobe cycle.
  logic [31:0] mem [WN];
  logic        p1v, p2v, q1v, q2v;
  logic [31:0] p1a, p2a, q1a, q2a;
  logic [31:0] ridx;

  always @(posedge clk) begin
    p1v <= rd;  p1a <= addr;  p2v <= p1v; p2a <= p1a;
    q1v <= rd1; q1a <= addr1; q2v <= q1v; q2a <= q1a;
  end

  assign ridx   = (p2a - BA) >> 2;
  assign rdata  = p2v ? mem[ridx[1:0]] : 32'hDEAD_BEEF;
  assign rdata1 = (q2v && q2a == 32'h100) ? 32'h1234_5678 : 32'hDEAD_BEEF;

  // Reference model and scoreboard.
  typedef struct {
    logic [15:0] d;
    logic        last;
    logic        first;
    int          start;
  } exp_t;

  exp_t        q[$];
  logic        start_flag;
  logic        ovr_flag;
  int          outstanding = 0;
  int          rd_idx = 0;
  int          n_rd = 0;
  int          n_hs = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_d;
  logic        prev_l;
  bit          lat_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_ram_rd", 32'(rd), 32'd0);
      chk("rst_valid", 32'(pv), 32'd0);
      chk("rst_last", 32'(pl), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(ovr), 32'd0);
      chk("rst_addr", addr, BA);
      q.delete();
      outstanding = 0;
      rd_idx      = 0;
      n_rd        = 0;
      n_hs        = 0;
      prev_stall  = 1'b0;
      lat_done    = 1'b0;
    end else begin
      chk("busy", 32'(busy), (outstanding > 0) ? 32'd1 : 32'd0);
      chk("overrun", 32'(ovr), 32'(ovr_flag));
      if (rd) begin
        chk("rd_addr", addr, BA + 32'(4 * rd_idx));
        chk("rd_in_frame", (rd_idx < WN) ? 32'd1 : 32'd0, 32'd1);
        rd_idx++;
        n_rd++;
        chk("occupancy", ((n_rd - n_hs / 2) <= 4) ? 32'd1 : 32'd0, 32'd1);
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(pv), 32'd1);
        chk("stall_data", 32'(pd), 32'(prev_d));
        chk("stall_last", 32'(pl), 32'(prev_l));
      end
      if (pv && q.size() > 0 && q[0].first && !lat_done) begin
        chk("first_latency", 32'(cyc - q[0].start), 32'd4);
        lat_done = 1'b1;
      end
      if (pv && pr) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pixel: got %h expected no pixel (cycle %0d)", pd, cyc);
        end else begin
          e = q.pop_front();
          chk("pix_data", 32'(pd), 32'(e.d));
          chk("pix_last", 32'(pl), 32'(e.last));
          if (e.first) lat_done = 1'b0;
          if (e.last) outstanding--;
        end
        n_hs++;
      end
      prev_stall = pv && !pr;
      prev_d     = pd;
      prev_l     = pl;
      if (start_flag) begin
        rd_idx = 0;
        outstanding++;
        for (int k = 0; k < WN; k++) begin
          for (int h = 0; h < 2; h++) begin
            e.d     = pix_fmt((h == 0) ? mem[k][31:16] : mem[k][15:0]);
            e.last  = (k == WN - 1) && (h == 1);
            e.first = (k == 0) && (h == 0);
            e.start = cyc;
            q.push_back(e);
          end
        end
      end
    end
  end

  // Sink ready pattern: 0 held high, 1 toggle, 2 held low, 3 random.
  int rdy_mode = 0;
  initial begin
    pr = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       pr = ~pr;
        2:       pr = 1'b0;
        3:       pr = 1'($urandom_range(0, 1));
        default: pr = 1'b1;
      endcase
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // kind 0: pulse expected to start a frame; kind 1: pulse expected to overrun.
  task automatic pulse_fd(input int kind);
    frame_done = 1'b1;
    if (kind == 0) start_flag = 1'b1;
    else           ovr_flag   = 1'b1;
    step();
    frame_done = 1'b0;
    start_flag = 1'b0;
    ovr_flag   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((outstanding > 0 || q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("frame_timeout", (n < budget) ? 32'd1 : 32'd0, 32'd1);
    step();
    step();
  endtask

  logic [15:0] pix1 [2];
  logic        last1 [2];
  int          n1rd;
  int          n1px;

  initial begin
    rst_n       = 1'b0;
    frame_done  = 1'b0;
    frame_done1 = 1'b0;
    start_flag  = 1'b0;
    ovr_flag    = 1'b0;
    pr1         = 1'b1;
    for (int k = 0; k < WN; k++)
      mem[k] = {16'(16'hA000 + 2 * k), 16'(16'hA001 + 2 * k)};
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Basic frame, ready held high.
    pulse_fd(0);
    wait_idle(40);

    // Ready toggling, then a long stall.
    rdy_mode = 1;
    pulse_fd(0);
    repeat (6) step();
    rdy_mode = 2;
    repeat (10) step();
    rdy_mode = 0;
    wait_idle(60);

    // Overrun 3 cycles in, then a pulse on the final handshake chains a new frame.
    pulse_fd(0);
    repeat (2) step();
    pulse_fd(1);
    repeat (7) step();
    pulse_fd(0);
    wait_idle(60);

    // Reset after 3 pixels aborts the frame; next frame is complete.
    pulse_fd(0);
    repeat (6) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (12) step();
    pulse_fd(0);
    wait_idle(40);

    // Randomized frames with random sink stalls and occasional overruns.
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < WN; k++) mem[k] = $urandom;
      if (f == 0) mem[0] = 32'h1234_5678;
      rdy_mode = 3;
      pulse_fd(0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 2)) step();
        pulse_fd(1);
      end
      wait_idle(300);
    end
    rdy_mode = 0;

    // Single-word frame on the second instance.
    n1rd = 0;
    n1px = 0;
    frame_done1 = 1'b1;
    step();
    frame_done1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rd1) begin
        n1rd++;
        chk("w1_addr", addr1, 32'h100);
      end
      if (pv1 && pr1) begin
        if (n1px < 2) begin
          pix1[n1px]  = pd1;
          last1[n1px] = pl1;
        end
        n1px++;
      end
    end
    chk("w1_reads", 32'(n1rd), 32'd1);
    chk("w1_pixels", 32'(n1px), 32'd2);
`ifdef ADC_FRAME_READER_BYTESWAP_EN
    chk("w1_pix0", 32'(pix1[0]), 32'h3412);
    chk("w1_pix1", 32'(pix1[1]), 32'h7856);
`else
    chk("w1_pix0", 32'(pix1[0]), 32'h1234);
    chk("w1_pix1", 32'(pix1[1]), 32'h5678);
`endif
    chk("w1_last0", 32'(last1[0]), 32'd0);
    chk("w1_last1", 32'(last1[1]), 32'd1);
    chk("w1_busy_end", 32'(busy1), 32'd0);
    chk("w1_overrun", 32'(ovr1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
